// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants and types for the router dispatch path
package router_pkg;

    localparam int NUM_OUT_PORTS  = 4;
    localparam int DEST_WIDTH     = 2;
    localparam int DROP_CNT_WIDTH = 16;

    typedef logic [DEST_WIDTH-1:0] dest_t;

    function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + DROP_CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/router_out_fifo.sv
// rtl/router_out_fifo.sv - per-channel output FIFO with synchronous flush
module router_out_fifo #(
    parameter  int DATA_WIDTH = 32,
    parameter  int FIFO_DEPTH = 4,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int LVL_W      = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  full,
    output logic                  empty,
    output logic [LVL_W-1:0]      level
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      count_q, count_d;
    logic                  do_push, do_pop;

    // Full/empty come from registered count, so a same-cycle pop never frees a slot for a push.
    assign full      = (count_q == LVL_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign level     = count_q;
    assign head_data = mem_q[rd_ptr_q];
    assign do_push   = push & ~full & ~flush;
    assign do_pop    = pop & ~empty & ~flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + LVL_W'(1);
                2'b01:   count_d = count_q - LVL_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/router_dispatch_ctrl.sv
// rtl/router_dispatch_ctrl.sv - destination decode, ID filter and per-output buffering
module router_dispatch_ctrl
    import router_pkg::*;
#(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int DEST_LSB   = 0,
    parameter  int ID_WIDTH   = 8,
    parameter  int ROUTER_ID  = 0,
    parameter  int FIFO_DEPTH = 4,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [ADDR_WIDTH-1:0]               in_addr,
    input  logic [DATA_WIDTH-1:0]               in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                flush,
    output logic [NUM_OUT_PORTS*DATA_WIDTH-1:0] out_data,
    output logic [NUM_OUT_PORTS-1:0]            out_valid,
    input  logic [NUM_OUT_PORTS-1:0]            out_ready,
    output logic [DROP_CNT_WIDTH-1:0]           drop_count,
    output logic [NUM_OUT_PORTS*LVL_W-1:0]      fifo_level
);

    dest_t                       dest;
    logic                        id_ok;
    logic                        accept;
    logic [NUM_OUT_PORTS-1:0]    full;
    logic [NUM_OUT_PORTS-1:0]    empty;
    logic [DROP_CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;
    logic                        unused_addr_bits;

    assign unused_addr_bits = ^in_addr;

    assign dest  = in_addr[DEST_LSB +: DEST_WIDTH];
    assign id_ok = (in_addr[ADDR_WIDTH-1 -: ID_WIDTH] == ID_WIDTH'(ROUTER_ID));

    // Foreign-ID words are always consumed so they can never stall the input stream.
    assign in_ready = reset & ~flush & (~id_ok | ~full[dest]);
    assign accept   = in_valid & in_ready;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (accept && !id_ok) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;

    for (genvar k = 0; k < NUM_OUT_PORTS; k++) begin : g_out
        router_out_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (reset),
            .flush     (flush),
            .push      (accept & id_ok & (dest == dest_t'(k))),
            .push_data (in_data),
            .pop       (out_ready[k]),
            .head_data (out_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .full      (full[k]),
            .empty     (empty[k]),
            .level     (fifo_level[k*LVL_W +: LVL_W])
        );
        assign out_valid[k] = ~empty[k];
    end

endmodule

// File: doc/router_dispatch_ctrl.md
Name: router_dispatch_ctrl

Overview:
Dispatch controller for the 1x4 router. It sits directly after the input port stage and accepts one word per cycle over a valid/ready handshake. It decodes the destination from the address, filters words addressed to other routers, and buffers each word in a per-output FIFO. The four output channels drain independently through their own valid/ready handshakes.

Parameters:
ADDR_WIDTH, 32, address bus width
DATA_WIDTH, 32, data bus width
DEST_LSB, 0, bit position of the 2-bit destination field in in_addr
ID_WIDTH, 8, width of the router-ID field, taken from in_addr MSBs; range 1..ADDR_WIDTH-2
ROUTER_ID, 0, value the ID field must match for a word to be accepted for routing
FIFO_DEPTH, 4, entries per output FIFO; power of two, minimum 2

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
in_addr  in  ADDR_WIDTH  address of the offered word
in_data  in  DATA_WIDTH  payload of the offered word
in_valid  in  1  offered word is valid
in_ready  out  1  controller takes the word this cycle
flush  in  1  synchronous clear of all FIFOs
out_data  out  4*DATA_WIDTH  head word per channel; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
out_valid  out  4  channel k head is valid
out_ready  in  4  channel k sink takes its head word
drop_count  out  16  saturating count of ID-mismatch drops
fifo_level  out  4*($clog2(FIFO_DEPTH)+1)  per-channel occupancy, packed like out_data

Behaviour:
- Reset (reset=0, asynchronous):
  - all FIFO pointers and counts clear; storage clears to 0
  - out_valid=0, out_data=0, drop_count=0, fifo_level=0
  - in_ready forced to 0 while reset=0
- Decode (combinational):
  - dest = in_addr[DEST_LSB +: 2]
  - id_ok = (in_addr[ADDR_WIDTH-1 -: ID_WIDTH] == ROUTER_ID)
- in_ready:
  - id_ok=0: in_ready=1 (mismatching words are consumed, never stall)
  - id_ok=1: in_ready = ~full[dest]
  - flush=1: in_ready=0
  - in_ready depends on in_addr but never on out_ready; there is no comb path from output to input.
- Accept = in_valid & in_ready.
  - id_ok=1: push {in_data} into FIFO[dest]; it becomes visible at out_valid[dest] on the next cycle if that FIFO was empty. Latency is 1 cycle; there is no same-cycle bypass.
  - id_ok=0: no push; drop_count += 1, saturating at 16'hFFFF.
- Pop on channel k = out_valid[k] & out_ready[k]. The head advances next cycle.
- out_data[k] is held stable while out_valid[k]=1 and out_ready[k]=0. Its value is don't-care when out_valid[k]=0.
- Simultaneous push and pop on the same channel:
  - not full: both occur and the count is unchanged.
  - full at cycle start: in_ready=0, so no push even though a pop frees a slot. Full is evaluated on registered state.
- Pointers wrap modulo FIFO_DEPTH. The count is held separately ($clog2+1 bits) to distinguish full from empty.
- flush=1: on the next edge all counts and pointers go to 0 and out_valid=0; any pop that cycle is discarded. drop_count is unaffected.
- Reset asserted mid-transfer: everything clears immediately, with no partial state. On release, the first valid word can be accepted on the first edge with reset=1.
- The four channels are independent; a stalled channel does not block words for other channels except via the in-order input stream (head-of-line blocking is accepted).

Decomposition:
- Shared package router_pkg:
  - NUM_OUT_PORTS=4
  - DEST_WIDTH=2
  - typedef dest_t (logic [1:0])
  - DROP_CNT_WIDTH=16
- One sub-module: router_out_fifo (DATA_WIDTH, FIFO_DEPTH, sync flush, push/pop, full/empty/level). It is instantiated 4 times via generate.
- The top level holds decode, in_ready logic, and the drop counter.

Test Plan:
1. Reset: hold reset=0 with in_valid=1 -> in_ready=0, out_valid=4'b0000, drop_count=0. After release, addr=32'h0000_0002, data=32'hA5A5_0001 -> out_valid=4'b0100 one cycle later, out_data[2]=32'hA5A5_0001.
2. Fill channel 1 with out_ready[1]=0:
   - 4 writes (addr=1, data 1..4) -> fifo_level[1]=4 and in_ready=0 for addr=1.
   - addr=3 still accepted.
   - then set out_ready[1]=1 -> data drains 1,2,3,4 in order.
3. ID mismatch: addr=32'h0100_0000 (ID=1) x3 -> in_ready=1, no out_valid change, drop_count=3. Preload drop_count near 16'hFFFF (force or long run) -> saturates at 16'hFFFF.
4. Full plus pop same cycle:
   - channel 0 full, out_ready[0]=1, push addr=0 -> push refused (in_ready=0), level goes 4->3.
   - next cycle the push is accepted and level stays at 3.
5. Flush: levels {1,2,3,4} on channels 0..3, pulse flush for 1 cycle -> all fifo_level=0 and out_valid=0 next cycle. drop_count is unchanged.
6. Async reset mid-stream: assert reset between edges while channel 2 holds 2 words -> out_valid=0 and fifo_level=0 immediately, without waiting for a clock edge.
